// File: rtl/auto_player.sv
// Auto-play song sequencer: steps through a per-song note ROM and drives fre/note_idx/busy/done.
// Optional LOOP_EN macro: at song end, pulse done and restart the same song instead of going idle.
module auto_player #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_000_000,
    parameter int MAX_NOTES   = 64,
    localparam int IW         = $clog2(MAX_NOTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic [1:0]    num,
    input  logic          start,
    input  logic          pause,
    output logic [31:0]   fre,
    output logic          busy,
    output logic [IW-1:0] note_idx,
    output logic          done
);
    localparam logic [1:0] MODE_AUTO = 2'b01;
    localparam logic [1:0] SONG_BAD  = 2'b11;
    localparam logic [6:0] END_ENTRY = {5'd31, 2'd0};

    typedef enum logic [1:0] {IDLE, PLAY, GAP, PAUSE} state_t;

    state_t        state, state_n, saved, saved_n;
    logic [1:0]    song, song_n;
    logic [IW-1:0] idx, idx_n;
    logic [31:0]   cnt, cnt_n;
    logic          done_q, done_n;
    logic [6:0]    cur, nxt;
    logic [31:0]   play_len;
    logic          start_ok, last_note;

    // Entry = {code[4:0], dur[1:0]}; anything past the written notes reads as END.
    function automatic logic [6:0] rom(input logic [1:0] s, input logic [IW-1:0] i);
        int k;
        k = int'(i);
        rom = END_ENTRY;
        case (s)
            2'd0: case (k)
                0, 1: rom = {5'd8, 2'd0};
                2, 3: rom = {5'd12, 2'd0};
                4, 5: rom = {5'd13, 2'd0};
                6:    rom = {5'd12, 2'd1};
                default: rom = END_ENTRY;
            endcase
            2'd1: case (k)
                0: rom = {5'd10, 2'd0};
                1: rom = {5'd9, 2'd1};
                2: rom = {5'd8, 2'd0};
                3: rom = {5'd0, 2'd0};
                4: rom = {5'd25, 2'd0};
                5: rom = {5'd21, 2'd2};
                default: rom = END_ENTRY;
            endcase
            2'd2: case (k)
                0: rom = {5'd1, 2'd3};
                1: rom = {5'd6, 2'd0};
                2: rom = {5'd15, 2'd1};
                default: rom = END_ENTRY;
            endcase
            default: rom = END_ENTRY;
        endcase
    endfunction

    // Note code -> tone frequency in Hz; rests and reserved codes are silent.
    function automatic logic [31:0] decode(input logic [4:0] c);
        case (c)
            5'd1:  decode = 32'd131;  5'd2:  decode = 32'd147;  5'd3:  decode = 32'd165;
            5'd4:  decode = 32'd175;  5'd5:  decode = 32'd196;  5'd6:  decode = 32'd220;
            5'd7:  decode = 32'd247;  5'd8:  decode = 32'd262;  5'd9:  decode = 32'd294;
            5'd10: decode = 32'd330;  5'd11: decode = 32'd349;  5'd12: decode = 32'd392;
            5'd13: decode = 32'd440;  5'd14: decode = 32'd494;  5'd15: decode = 32'd523;
            5'd16: decode = 32'd587;  5'd17: decode = 32'd659;  5'd18: decode = 32'd698;
            5'd19: decode = 32'd784;  5'd20: decode = 32'd880;  5'd21: decode = 32'd988;
            default: decode = 32'd0;
        endcase
    endfunction

    assign cur       = rom(song, idx);
    assign nxt       = rom(song, idx + 1'b1);
    assign play_len  = 32'((int'(cur[1:0]) + 1) * BEAT_CYCLES - GAP_CYCLES);
    assign last_note = (idx == IW'(MAX_NOTES - 1)) || ((nxt | 7'b0000011) == 7'b1111111);
    assign start_ok  = start && (mode == MODE_AUTO) && (num != SONG_BAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            saved  <= PLAY;
            song   <= 2'd0;
            idx    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            saved  <= saved_n;
            song   <= song_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            done_q <= done_n;
        end
    end

    // Priority: abort > restart > normal advance; pause wraps whatever the advance produced.
    always_comb begin
        state_n = state;
        saved_n = saved;
        song_n  = song;
        idx_n   = idx;
        cnt_n   = cnt;
        done_n  = 1'b0;
        if (state != IDLE && mode != MODE_AUTO) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (start_ok) begin
            song_n  = num;
            idx_n   = '0;
            cnt_n   = '0;
            saved_n = PLAY;
            state_n = pause ? PAUSE : PLAY;
        end else begin
            case (state)
                PLAY, GAP: begin
                    if (state == PLAY) begin
                        if (cnt == play_len - 32'd1) begin
                            state_n = GAP;
                            cnt_n   = '0;
                        end else cnt_n = cnt + 32'd1;
                    end else if (cnt == 32'(GAP_CYCLES - 1)) begin
                        cnt_n = '0;
                        if (last_note) begin
                            done_n = 1'b1;
`ifdef LOOP_EN
                            idx_n   = '0;
                            state_n = PLAY;
`else
                            state_n = IDLE;
`endif
                        end else begin
                            idx_n   = idx + 1'b1;
                            state_n = PLAY;
                        end
                    end else cnt_n = cnt + 32'd1;
                    if (pause && state_n != IDLE) begin
                        saved_n = state_n;
                        state_n = PAUSE;
                    end
                end
                PAUSE:   if (!pause) state_n = saved;
                default: ;
            endcase
        end
    end

    always_comb begin
        fre      = (state == PLAY) ? decode(cur[6:2]) : 32'd0;
        busy     = (state != IDLE);
        note_idx = idx;
        done     = done_q;
    end
endmodule

// File: tb/tb_auto_player.sv
// Randomized + directed bench for auto_player; expected outputs come from a per-song cycle timeline.
module tb_auto_player;
    localparam int BEAT = 10;
    localparam int GAPC = 2;
    localparam logic [1:0] AUTO = 2'b01, FREE = 2'b00;

    logic clk = 0, rst_n = 0;
    logic [1:0] mode = AUTO, num = 0;
    logic start = 0, pause = 0;
    logic [31:0] fre;
    logic busy, done;
    logic [5:0] note_idx;

    auto_player #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC), .MAX_NOTES(64)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .num(num), .start(start), .pause(pause),
        .fre(fre), .busy(busy), .note_idx(note_idx), .done(done));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    int freq_tab[22] = '{0, 131, 147, 165, 175, 196, 220, 247, 262, 294, 330, 349,
                         392, 440, 494, 523, 587, 659, 698, 784, 880, 988};

    // Song tables as {code, dur}; END (31) terminates.
    function automatic int song_code(int s, int i);
        int s1c[8] = '{8, 8, 12, 12, 13, 13, 12, 31};
        int s2c[7] = '{10, 9, 8, 0, 25, 21, 31};
        int s3c[4] = '{1, 6, 15, 31};
        if (s == 0) return (i < 8) ? s1c[i] : 31;
        if (s == 1) return (i < 7) ? s2c[i] : 31;
        return (i < 4) ? s3c[i] : 31;
    endfunction

    function automatic int song_dur(int s, int i);
        int s1d[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        int s2d[7] = '{0, 1, 0, 0, 0, 2, 0};
        int s3d[4] = '{3, 0, 1, 0};
        if (s == 0) return (i < 8) ? s1d[i] : 0;
        if (s == 1) return (i < 7) ? s2d[i] : 0;
        return (i < 4) ? s3d[i] : 0;
    endfunction

    typedef struct { int f; int idx; } slot_t;
    slot_t q[$];
    bit active = 0, paused = 0, m_done = 0;
    int last_song = 0;

    // Whole-song timeline: one slot per audible or gap cycle.
    task automatic build(input int s);
        q.delete();
        last_song = s;
        for (int i = 0; i < 64; i++) begin
            int c, len;
            slot_t sl;
            c = song_code(s, i);
            if (c == 31) break;
            len = (song_dur(s, i) + 1) * BEAT - GAPC;
            sl.idx = i;
            sl.f = (c <= 21) ? freq_tab[c] : 0;
            for (int k = 0; k < len; k++) q.push_back(sl);
            sl.f = 0;
            for (int k = 0; k < GAPC; k++) q.push_back(sl);
        end
    endtask

    task automatic model_step();
        m_done = 0;
        if (!rst_n) begin
            active = 0; paused = 0; q.delete();
        end else if (active && mode != AUTO) begin
            active = 0; q.delete();
        end else if (start && mode == AUTO && num != 2'b11) begin
            build(int'(num)); active = 1; paused = pause;
        end else if (active) begin
            if (paused) begin
                if (!pause) paused = 0;
            end else begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    m_done = 1;
`ifdef LOOP_EN
                    build(last_song); paused = pause;
`else
                    active = 0;
`endif
                end else paused = pause;
            end
        end
    endtask

    task automatic compare();
        chk("fre", fre, (active && !paused) ? 32'(q[0].f) : 32'd0);
        chk("busy", 32'(busy), 32'(active));
        chk("done", 32'(done), 32'(m_done));
        if (active) chk("note_idx", 32'(note_idx), 32'(q[0].idx));
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare();
            start = 0;
        end
    endtask

    task automatic go(input logic [1:0] s);
        num = s; start = 1; tick();
    endtask

    initial begin
        #1;
        chk("rst_fre", fre, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_idx", 32'(note_idx), 0);
        chk("rst_done", 32'(done), 0);
        tick(2);
        rst_n = 1;
        tick(2);

        // full song1, then pause in note 0, abort, ignored starts, restart, start+pause
        go(2'd0); tick(90);
        go(2'd0); tick(2); pause = 1; tick(5); pause = 0; tick(12);
        mode = FREE; tick(2); mode = AUTO; tick(2);
        mode = FREE; go(2'd0); tick(3); mode = AUTO;
        go(2'b11); tick(3);
        go(2'd0); tick(25); go(2'd1); tick(30);
        pause = 1; go(2'd2); tick(4); pause = 0; tick(60);
        go(2'd1); tick(130);

        // async reset mid-note
        go(2'd2); tick(5);
        #2 rst_n = 0;
        #1;
        chk("arst_fre", fre, 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_idx", 32'(note_idx), 0);
        active = 0; paused = 0; q.delete();
        tick(1);
        rst_n = 1;
        tick(4);

        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 99) == 0);
            num = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) pause = ~pause;
            mode = ($urandom_range(0, 249) == 0) ? 2'($urandom_range(0, 3)) : AUTO;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
